// File: rtl/spi_xip_pkg.sv
// Shared definitions for the SPI NOR execute-in-place bridge.
package spi_xip_pkg;

   localparam logic [4:0] OFS_RX0  = 5'h00;
   localparam logic [4:0] OFS_TX0  = 5'h00;
   localparam logic [4:0] OFS_TX1  = 5'h04;
   localparam logic [4:0] OFS_CTRL = 5'h10;

   localparam logic [7:0] READ_CMD_DEF = 8'h03;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_TX1  = 3'd1,
      ST_WR_TX0  = 3'd2,
      ST_WR_CTRL = 3'd3,
      ST_POLL    = 3'd4,
      ST_RD_RX   = 3'd5,
      ST_RESP    = 3'd6
   } xip_state_t;

   // States that own a downstream APB transfer.
   function automatic logic is_xfer_state(input xip_state_t s);
      logic r;
      case (s)
         ST_WR_TX1, ST_WR_TX0, ST_WR_CTRL, ST_POLL, ST_RD_RX: r = 1'b1;
         default:                                            r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/spi_xip_bridge_apb_single_master.sv
// One APB transfer at a time; a start coinciding with done chains straight
// into the next SETUP so back-to-back transfers leave no idle cycle.
module apb_single_master (
   input  logic        PCLK,
   input  logic        PRESETN,
   input  logic        start_i,
   input  logic [4:0]  addr_i,
   input  logic        write_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic [4:0]  paddr_o,
   output logic        psel_o,
   output logic        penable_o,
   output logic        pwrite_o,
   output logic [31:0] pwdata_o,
   input  logic [31:0] prdata_i,
   input  logic        pready_i,
   input  logic        pslverr_i
);

   logic        psel_q, psel_d;
   logic        penable_q, penable_d;
   logic        pwrite_q, pwrite_d;
   logic [4:0]  paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;

   assign done_o    = psel_q & penable_q & pready_i;
   assign busy_o    = psel_q;
   assign rdata_o   = prdata_i;
   assign err_o     = pslverr_i;
   assign psel_o    = psel_q;
   assign penable_o = penable_q;
   assign pwrite_o  = pwrite_q;
   assign paddr_o   = paddr_q;
   assign pwdata_o  = pwdata_q;

   // Phase sequencing; address/control are only loaded when a SETUP begins.
   always_comb begin
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      if (done_o) begin
         if (start_i) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = write_i;
            paddr_d   = addr_i;
            pwdata_d  = wdata_i;
         end else begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      end else if (psel_q && !penable_q) begin
         penable_d = 1'b1;
      end else if (!psel_q && start_i) begin
         psel_d    = 1'b1;
         penable_d = 1'b0;
         pwrite_d  = write_i;
         paddr_d   = addr_i;
         pwdata_d  = wdata_i;
      end else begin
         psel_d    = psel_q;
         penable_d = penable_q;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= 5'h00;
         pwdata_q  <= 32'h0000_0000;
      end else begin
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
      end
   end

endmodule

// File: rtl/spi_xip_bridge.sv
// Read-only XIP bridge: turns each upstream APB word read into a scripted
// 0x03 READ sequence on the SPI controller's APB slave port.
module spi_xip_bridge
   import spi_xip_pkg::*;
#(
   parameter logic [31:0] CTRL_VAL = 32'h0000_2540,
   parameter int          GO_BIT   = 8,
   parameter int          POLL_MAX = 1024,
   parameter logic [7:0]  READ_CMD = READ_CMD_DEF
) (
   input  logic        PCLK,
   input  logic        PRESETN,
   input  logic [31:0] s_paddr,
   input  logic        s_psel,
   input  logic        s_penable,
   input  logic        s_pwrite,
   input  logic [31:0] s_pwdata,
   output logic [31:0] s_prdata,
   output logic        s_pready,
   output logic        s_pslverr,
   output logic [4:0]  m_paddr,
   output logic        m_psel,
   output logic        m_penable,
   output logic        m_pwrite,
   output logic [31:0] m_pwdata,
   input  logic [31:0] m_prdata,
   input  logic        m_pready,
   input  logic        m_pslverr
);

   localparam int             PW        = $clog2(POLL_MAX + 1);
   localparam logic [PW-1:0]  POLL_LAST = PW'(POLL_MAX - 1);

   xip_state_t    state_q, state_d;
   logic [PW-1:0] poll_q, poll_d;
   logic [21:0]   addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic          err_q, err_d;
   logic          s_pready_q, s_pslverr_q;

   logic          start_s, x_write_s, mst_busy_s, mst_done_s, mst_err_s;
   logic [4:0]    x_addr_s;
   logic [31:0]   x_wdata_s, mst_rdata_s;
   logic          unused_s;

   assign unused_s  = ^{s_pwdata, s_paddr[31:24], s_paddr[1:0]};
   assign s_prdata  = data_q;
   assign s_pready  = s_pready_q;
   assign s_pslverr = s_pslverr_q;

   // Sequencer next state; any downstream error ends the sequence in RESP.
   always_comb begin
      state_d = state_q;
      poll_d  = poll_q;
      addr_d  = addr_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            poll_d = '0;
            if (s_psel && s_penable) begin
               if (s_pwrite) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  err_d   = 1'b0;
                  addr_d  = s_paddr[23:2];
                  state_d = ST_WR_TX1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WR_TX1, ST_WR_TX0, ST_WR_CTRL, ST_POLL, ST_RD_RX: begin
            if (mst_done_s) begin
               if (mst_err_s) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  case (state_q)
                     ST_WR_TX1:  state_d = ST_WR_TX0;
                     ST_WR_TX0:  state_d = ST_WR_CTRL;
                     ST_WR_CTRL: state_d = ST_POLL;
                     ST_POLL: begin
                        if (!mst_rdata_s[GO_BIT]) begin
                           state_d = ST_RD_RX;
                        end else if (poll_q == POLL_LAST) begin
                           err_d   = 1'b1;
                           state_d = ST_RESP;
                        end else begin
                           poll_d  = poll_q + PW'(1);
                        end
                     end
                     ST_RD_RX: begin
                        data_d  = mst_rdata_s;
                        state_d = ST_RESP;
                     end
                     default: state_d = ST_IDLE;
                  endcase
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Launch when a transfer state is first settled in, or chain on done.
   always_comb begin
      start_s   = is_xfer_state(state_q) && is_xfer_state(state_d) && (mst_done_s || !mst_busy_s);
      x_addr_s  = 5'h00;
      x_write_s = 1'b0;
      x_wdata_s = 32'h0000_0000;
      case (state_d)
         ST_WR_TX1: begin
            x_addr_s  = OFS_TX1;
            x_write_s = 1'b1;
            x_wdata_s = {READ_CMD, addr_q, 2'b00};
         end
         ST_WR_TX0: begin
            x_addr_s  = OFS_TX0;
            x_write_s = 1'b1;
         end
         ST_WR_CTRL: begin
            x_addr_s  = OFS_CTRL;
            x_write_s = 1'b1;
            x_wdata_s = CTRL_VAL;
         end
         ST_POLL:  x_addr_s = OFS_CTRL;
         ST_RD_RX: x_addr_s = OFS_RX0;
         default:  x_addr_s = 5'h00;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q     <= ST_IDLE;
         poll_q      <= '0;
         addr_q      <= 22'h0;
         data_q      <= 32'h0000_0000;
         err_q       <= 1'b0;
         s_pready_q  <= 1'b0;
         s_pslverr_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         poll_q      <= poll_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         err_q       <= err_d;
         s_pready_q  <= (state_d == ST_RESP);
         s_pslverr_q <= (state_d == ST_RESP) && err_d;
      end
   end

   apb_single_master u_mst (
      .PCLK      (PCLK),
      .PRESETN   (PRESETN),
      .start_i   (start_s),
      .addr_i    (x_addr_s),
      .write_i   (x_write_s),
      .wdata_i   (x_wdata_s),
      .busy_o    (mst_busy_s),
      .done_o    (mst_done_s),
      .rdata_o   (mst_rdata_s),
      .err_o     (mst_err_s),
      .paddr_o   (m_paddr),
      .psel_o    (m_psel),
      .penable_o (m_penable),
      .pwrite_o  (m_pwrite),
      .pwdata_o  (m_pwdata),
      .prdata_i  (m_prdata),
      .pready_i  (m_pready),
      .pslverr_i (m_pslverr)
   );

endmodule

// File: tb/tb_spi_xip_bridge.sv
// Scoreboard bench: expected downstream transfers and upstream responses are
// queued when a read is issued and popped as the bridge produces them.
module tb_spi_xip_bridge;
   import spi_xip_pkg::*;

   localparam logic [31:0] CTRL_V = 32'h0000_2540;
   localparam logic [31:0] RX_KEY = 32'h5A5A_0F0F;

   typedef struct packed { logic wr; logic [4:0] addr; logic [31:0] wdata; } dn_t;
   typedef struct packed { logic [31:0] data; logic err; logic chk_data; } up_t;

   logic        PCLK = 1'b0;
   logic        PRESETN = 1'b0;
   logic [31:0] s_paddr = 32'h0, s_pwdata = 32'h0, s_prdata;
   logic        s_psel = 1'b0, s_penable = 1'b0, s_pwrite = 1'b0;
   logic        s_pready, s_pslverr;
   logic [4:0]  m_paddr;
   logic        m_psel, m_penable, m_pwrite;
   logic [31:0] m_pwdata;
   logic [31:0] m_prdata = 32'h0;
   logic        m_pready = 1'b0, m_pslverr = 1'b0;

   spi_xip_bridge #(.CTRL_VAL(CTRL_V), .GO_BIT(8), .POLL_MAX(4), .READ_CMD(8'h03)) dut (
      .PCLK(PCLK), .PRESETN(PRESETN),
      .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
      .s_pwdata(s_pwdata), .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
      .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
      .m_pwdata(m_pwdata), .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
   );

   always #5 PCLK = ~PCLK;

   dn_t exp_dn[$];
   up_t exp_up[$];
   int  n_chk = 0, n_pass = 0, proto_viol = 0, psel_cycles = 0;
   int  go_polls = 0, go_left = 0;
   bit  rand_wait = 1'b0, use_fixed = 1'b0, err_en = 1'b0, saw_ctrl_rd = 1'b0;
   logic [31:0] rx_fixed = 32'h0, tx1_m = 32'h0, ctrl_m = 32'h0;
   logic [4:0]  err_addr = 5'h00;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic dn_t mk_dn(input logic wr, input logic [4:0] a, input logic [31:0] d);
      dn_t t;
      t.wr = wr; t.addr = a; t.wdata = d;
      return t;
   endfunction

   function automatic up_t mk_up(input logic [31:0] d, input logic e, input logic c);
      up_t t;
      t.data = d; t.err = e; t.chk_data = c;
      return t;
   endfunction

   function automatic logic [31:0] tx1_of(input logic [31:0] a);
      return {8'h03, a[23:2], 2'b00};
   endfunction

   task automatic push_read(input logic [31:0] a, input int ctrl_reads, input bit reach_rx);
      exp_dn.push_back(mk_dn(1'b1, OFS_TX1, tx1_of(a)));
      exp_dn.push_back(mk_dn(1'b1, OFS_TX0, 32'h0));
      exp_dn.push_back(mk_dn(1'b1, OFS_CTRL, CTRL_V));
      for (int i = 0; i < ctrl_reads; i++) exp_dn.push_back(mk_dn(1'b0, OFS_CTRL, 32'h0));
      if (reach_rx) exp_dn.push_back(mk_dn(1'b0, OFS_RX0, 32'h0));
   endtask

   // Controller model, downstream protocol checker and upstream pready monitor.
   initial begin
      int wcnt; bit pend; bit prev_rdy; logic [4:0] sa; logic sw; logic [31:0] swd;
      dn_t got, e;
      wcnt = 0; pend = 1'b0; prev_rdy = 1'b0; sa = 5'h0; sw = 1'b0; swd = 32'h0;
      forever begin
         @(posedge PCLK); #1;
         if (!PRESETN) begin
            m_pready = 1'b0; m_pslverr = 1'b0; pend = 1'b0; prev_rdy = 1'b0;
            continue;
         end
         if (s_pready && (prev_rdy || !(s_psel && s_penable))) proto_viol++;
         prev_rdy = s_pready;
         if (m_psel) psel_cycles++;
         m_pready = 1'b0; m_pslverr = 1'b0;
         if (m_penable && !m_psel) proto_viol++;
         if (m_psel && !m_penable) begin
            if (pend) proto_viol++;
            pend = 1'b1; sa = m_paddr; sw = m_pwrite; swd = m_pwdata;
            wcnt = rand_wait ? int'($urandom_range(0, 3)) : 1;
            if (!m_pwrite && m_paddr == OFS_CTRL) saw_ctrl_rd = 1'b1;
         end else if (m_psel && m_penable) begin
            if (!pend) proto_viol++;
            if (m_paddr !== sa || m_pwrite !== sw || m_pwdata !== swd) proto_viol++;
            if (wcnt > 0) begin
               wcnt--;
            end else begin
               m_pready = 1'b1; pend = 1'b0;
               got = mk_dn(sw, sa, sw ? swd : 32'h0);
               chk("dn_expected", exp_dn.size() > 0, 1);
               if (exp_dn.size() > 0) begin
                  e = exp_dn.pop_front();
                  chk("dn_xfer", got, e);
               end
               if (sw) begin
                  m_pslverr = err_en && (sa == err_addr);
                  if (sa == OFS_TX1) tx1_m = swd;
                  if (sa == OFS_CTRL) begin ctrl_m = swd; go_left = go_polls; end
               end else if (sa == OFS_CTRL) begin
                  m_prdata = ctrl_m & ~32'h0000_0100;
                  if (go_left > 0) begin m_prdata[8] = 1'b1; go_left--; end
               end else begin
                  m_prdata = use_fixed ? rx_fixed : (tx1_m ^ RX_KEY);
               end
            end
         end else if (pend) begin
            proto_viol++;
         end
      end
   end

   task automatic up_xfer(input logic [31:0] a, input bit wr, input int exp_lat);
      int n; up_t e;
      @(posedge PCLK); #1;
      s_psel = 1'b1; s_penable = 1'b0; s_pwrite = wr; s_paddr = a; s_pwdata = $urandom;
      @(posedge PCLK); #1;
      s_penable = 1'b1;
      n = 0;
      do begin @(negedge PCLK); n++; end while (!s_pready && n < 400);
      chk("resp_seen", s_pready, 1);
      if (s_pready) begin
         chk("up_expected", exp_up.size() > 0, 1);
         if (exp_up.size() > 0) begin
            e = exp_up.pop_front();
            chk("pslverr", s_pslverr, e.err);
            if (e.chk_data) chk("prdata", s_prdata, e.data);
            if (exp_lat >= 0) chk("latency", n - 1, exp_lat);
         end
      end
   endtask

   task automatic up_idle();
      @(posedge PCLK); #1;
      s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
      @(negedge PCLK);
      chk("pready_pulse", s_pready, 0);
   endtask

   task automatic chk_reset_outs();
      chk("rst_m_psel", m_psel, 0);      chk("rst_m_penable", m_penable, 0);
      chk("rst_m_pwrite", m_pwrite, 0);  chk("rst_m_paddr", m_paddr, 0);
      chk("rst_m_pwdata", m_pwdata, 0);  chk("rst_s_pready", s_pready, 0);
      chk("rst_s_pslverr", s_pslverr, 0); chk("rst_s_prdata", s_prdata, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n; int p0;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      chk_reset_outs();
      PRESETN = 1'b1;

      // Nominal read: two GO=1 polls, fixed RX word, registered-ready controller.
      use_fixed = 1'b1; rx_fixed = 32'hDEAD_BEEF; go_polls = 2;
      push_read(32'h3000_0124, 3, 1'b1);
      exp_up.push_back(mk_up(32'hDEAD_BEEF, 1'b0, 1'b1));
      up_xfer(32'h3000_0124, 1'b0, 23);
      up_idle();
      chk("drain_nominal", exp_dn.size(), 0);

      // Upstream write is refused with no downstream traffic.
      p0 = psel_cycles;
      exp_up.push_back(mk_up(32'h0, 1'b1, 1'b0));
      up_xfer(32'h0000_0040, 1'b1, 1);
      up_idle();
      chk("write_no_dn", psel_cycles - p0, 0);

      // GO stuck high: POLL_MAX reads then error.
      go_polls = 1000;
      push_read(32'h0000_0800, 4, 1'b0);
      exp_up.push_back(mk_up(32'h0, 1'b1, 1'b0));
      up_xfer(32'h0000_0800, 1'b0, 23);
      up_idle();
      chk("drain_timeout", exp_dn.size(), 0);

      // Slave error on the TX0 write aborts before CTRL.
      err_en = 1'b1; err_addr = OFS_TX0; go_polls = 0;
      exp_dn.push_back(mk_dn(1'b1, OFS_TX1, tx1_of(32'h0000_0100)));
      exp_dn.push_back(mk_dn(1'b1, OFS_TX0, 32'h0));
      exp_up.push_back(mk_up(32'h0, 1'b1, 1'b0));
      up_xfer(32'h0000_0100, 1'b0, 8);
      up_idle();
      err_en = 1'b0;
      chk("drain_slverr", exp_dn.size(), 0);

      // Asynchronous reset while polling, then a normal read.
      go_polls = 1000; saw_ctrl_rd = 1'b0;
      push_read(32'h0000_0200, 0, 1'b0);
      @(posedge PCLK); #1;
      s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b0; s_paddr = 32'h0000_0200;
      @(posedge PCLK); #1;
      s_penable = 1'b1;
      n = 0;
      while (!saw_ctrl_rd && n < 100) begin @(posedge PCLK); n++; end
      chk("poll_reached", saw_ctrl_rd, 1);
      #3;
      PRESETN = 1'b0;
      #1;
      chk_reset_outs();
      chk("drain_reset", exp_dn.size(), 0);
      exp_dn.delete();
      s_psel = 1'b0; s_penable = 1'b0;
      repeat (2) @(negedge PCLK);
      PRESETN = 1'b1;
      use_fixed = 1'b0; go_polls = 1;
      push_read(32'h0000_1234, 2, 1'b1);
      exp_up.push_back(mk_up(tx1_of(32'h0000_1234) ^ RX_KEY, 1'b0, 1'b1));
      up_xfer(32'h0000_1234, 1'b0, 20);
      up_idle();
      chk("drain_after_reset", exp_dn.size(), 0);

      // Back-to-back reads with random controller wait states.
      rand_wait = 1'b1; go_polls = 1;
      push_read(32'h0000_0000, 2, 1'b1);
      push_read(32'h0000_0004, 2, 1'b1);
      exp_up.push_back(mk_up(tx1_of(32'h0000_0000) ^ RX_KEY, 1'b0, 1'b1));
      exp_up.push_back(mk_up(tx1_of(32'h0000_0004) ^ RX_KEY, 1'b0, 1'b1));
      up_xfer(32'h0000_0000, 1'b0, -1);
      up_xfer(32'h0000_0004, 1'b0, -1);
      up_idle();
      chk("drain_b2b", exp_dn.size(), 0);

      chk("protocol", proto_viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
